// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the fetch FSM state encoding, the opcode field bounds (also used by
// the main decoder), the sequential PC increment and the default reset PC.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_STALL = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_e;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned PC_INCR    = 4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_skid.sv
// fetch_skid_buf: 1-entry {instr, pc_plus4} holding register.
// Ports:
//   clk_i, rst_i        clock, async active-low reset
//   load_i              capture instr_i/pc_plus4_i and mark valid
//   clear_i             drop the held entry (wins over load_i)
//   instr_i, pc_plus4_i entry to capture
//   valid_o             entry held
//   instr_o, pc_plus4_o held entry
module fetch_skid_buf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] pc_plus4_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_plus4_o
);

  logic              r_valid;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc_plus4;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc_plus4 <= '0;
    end else if (clear_i) begin
      r_valid <= 1'b0;
    end else if (load_i) begin
      r_valid    <= 1'b1;
      r_instr    <= instr_i;
      r_pc_plus4 <= pc_plus4_i;
    end
  end

  assign valid_o    = r_valid;
  assign instr_o    = r_instr;
  assign pc_plus4_o = r_pc_plus4;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage feeding the main decoder.
// Owns the PC, fetches one word at a time over a req/ack handshake, buffers
// up to two instructions (IF/ID register + skid) and squashes in-flight
// fetches on redirect.
// Ports:
//   clk_i, rst_i                 clock, async active-low reset
//   imem_req_o/addr_o            fetch request, address stable while req=1
//   imem_ack_i/rdata_i           memory response
//   redirect_i/redirect_pc_i     taken branch/jump target (word aligned here)
//   id_ready_i                   decode can accept
//   id_valid_o/instr_o/
//   id_pc_plus4_o/op_o           IF/ID register outputs
//
// state   | meaning
// S_IDLE  | one dead cycle after reset release
// S_REQ   | requesting imem at pc
// S_STALL | output and skid full, waiting for decode to take
// S_DROP  | squashed request still outstanding, data will be discarded
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              id_ready_i,
  output logic              id_valid_o,
  output logic [DATA_W-1:0] id_instr_o,
  output logic [ADDR_W-1:0] id_pc_plus4_o,
  output logic [5:0]        id_op_o
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_drop_addr;
  logic              r_id_valid;
  logic [DATA_W-1:0] r_id_instr;
  logic [ADDR_W-1:0] r_id_pc4;

  logic              w_take;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_skid_load;
  logic              w_skid_clr;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_instr;
  logic [ADDR_W-1:0] w_skid_pc4;

  assign w_take        = r_id_valid && id_ready_i;
  assign w_redirect    = redirect_i && (r_state != S_IDLE);
  assign w_redirect_pc = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign w_pc_next     = r_pc + ADDR_W'(PC_INCR);

  // Returned word goes to the skid only when the output is full and stays full.
  assign w_skid_load = (r_state == S_REQ) && imem_ack_i && !w_redirect &&
                       r_id_valid && !w_take;
  assign w_skid_clr  = w_redirect || ((r_state == S_STALL) && w_take);

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_skid_load),
    .clear_i    (w_skid_clr),
    .instr_i    (imem_rdata_i),
    .pc_plus4_i (w_pc_next),
    .valid_o    (w_skid_valid),
    .instr_o    (w_skid_instr),
    .pc_plus4_o (w_skid_pc4)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_drop_addr <= '0;
      r_id_valid  <= 1'b0;
      r_id_instr  <= '0;
      r_id_pc4    <= '0;
    end else if (w_redirect) begin
      // A take in this cycle has already been seen by decode; just invalidate.
      r_id_valid <= 1'b0;
      r_pc       <= w_redirect_pc;
      case (r_state)
        S_REQ: begin
          if (!imem_ack_i) begin
            r_state     <= S_DROP;
            r_drop_addr <= r_pc;
          end
        end
        S_STALL: r_state <= S_REQ;
        default: r_state <= r_state;
      endcase
    end else begin
      if (w_take) r_id_valid <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imem_ack_i) begin
            r_pc <= w_pc_next;
            if (!r_id_valid || w_take) begin
              r_id_valid <= 1'b1;
              r_id_instr <= imem_rdata_i;
              r_id_pc4   <= w_pc_next;
            end else begin
              r_state <= S_STALL;
            end
          end
        end
        S_STALL: begin
          if (w_take && w_skid_valid) begin
            r_id_valid <= 1'b1;
            r_id_instr <= w_skid_instr;
            r_id_pc4   <= w_skid_pc4;
            r_state    <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_ack_i) r_state <= S_REQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req_o    = (r_state == S_REQ) || (r_state == S_DROP);
  assign imem_addr_o   = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign id_valid_o    = r_id_valid;
  assign id_instr_o    = r_id_instr;
  assign id_pc_plus4_o = r_id_pc4;
  assign id_op_o       = r_id_instr[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk_i;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_plus4_o;
  logic [5:0]  id_op_o;

  // second instance starting just below the top of the address space
  logic        wrap_req;
  logic [31:0] wrap_addr;
  logic        wrap_ack;
  logic [31:0] wrap_rdata;
  logic        wrap_redirect;
  logic [31:0] wrap_redirect_pc;
  logic        wrap_ready;
  logic        wrap_valid;
  logic [31:0] wrap_instr;
  logic [31:0] wrap_pc4;
  logic [5:0]  wrap_op;

  int n_checks = 0;
  int n_errors = 0;

  // memory / scoreboard state
  logic [31:0] exp_addr;
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat_max;
  logic [31:0] slow_addr;
  int          slow_lat;
  int          since;
  int          n_takes;
  logic [31:0] issued[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2001_0005;
  endfunction

  instr_fetch_unit u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_ready_i    (id_ready_i),
    .id_valid_o    (id_valid_o),
    .id_instr_o    (id_instr_o),
    .id_pc_plus4_o (id_pc_plus4_o),
    .id_op_o       (id_op_o)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (wrap_req),
    .imem_addr_o   (wrap_addr),
    .imem_ack_i    (wrap_ack),
    .imem_rdata_i  (wrap_rdata),
    .redirect_i    (wrap_redirect),
    .redirect_pc_i (wrap_redirect_pc),
    .id_ready_i    (wrap_ready),
    .id_valid_o    (wrap_valid),
    .id_instr_o    (wrap_instr),
    .id_pc_plus4_o (wrap_pc4),
    .id_op_o       (wrap_op)
  );

  assign wrap_ack   = wrap_req;
  assign wrap_rdata = mem_word(wrap_addr);

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i        = 1'b0;
    id_ready_i   = 1'b0;
    redirect_i   = 1'b0;
    redirect_pc_i = '0;
    imem_ack_i   = 1'b0;
    imem_rdata_i = '0;
    mem_busy     = 1'b0;
    issued.delete();
    repeat (2) @(negedge clk_i);
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    chk("rst_req",   32'(imem_req_o), 32'd0);
    chk("rst_instr", id_instr_o, 32'd0);
    chk("rst_pc4",   id_pc_plus4_o, 32'd0);
    chk("rst_wrap_valid", 32'(wrap_valid), 32'd0);
    rst_i    = 1'b1;
    exp_addr = 32'h0;
    since    = 0;
  endtask

  // One clock: drive inputs at negedge, update the reference, advance.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
    logic [31:0] w;
    id_ready_i    = rdy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    if (imem_req_o) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr_o;
        mem_cnt  = (imem_addr_o == slow_addr) ? slow_lat : int'($urandom_range(lat_max));
        issued.push_back(imem_addr_o);
      end else begin
        chk("addr_hold", imem_addr_o, mem_addr);
      end
      if (mem_cnt == 0) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = mem_word(imem_addr_o);
        mem_busy     = 1'b0;
      end else begin
        imem_ack_i   = 1'b0;
        imem_rdata_i = $urandom;
        mem_cnt--;
      end
    end else begin
      imem_ack_i   = 1'b0;
      imem_rdata_i = $urandom;
      mem_busy     = 1'b0;
    end
    if (id_valid_o && rdy) begin
      w = mem_word(exp_addr);
      chk("take_instr", id_instr_o, w);
      chk("take_pc4",   id_pc_plus4_o, exp_addr + 32'd4);
      chk("take_op",    32'(id_op_o), {26'd0, w[31:26]});
      exp_addr = exp_addr + 32'd4;
      n_takes++;
    end
    if (redir && since != 0) exp_addr = {tgt[31:2], 2'b00};
    @(negedge clk_i);
    since++;
  endtask

  task automatic run_until_addr(input logic [31:0] a, input int budget);
    int n = 0;
    while (!(imem_req_o && imem_addr_o == a) && n < budget) begin
      cycle(1'b1, 1'b0, 32'h0);
      n++;
    end
    if (n >= budget) chk("timeout_addr", 32'd0, 32'd1);
  endtask

  initial begin
    int idx;
    int n;
    int takes0;
    wrap_redirect    = 1'b0;
    wrap_redirect_pc = '0;
    wrap_ready       = 1'b0;
    lat_max   = 0;
    slow_addr = 32'hFFFF_FFFF;
    slow_lat  = 0;
    n_takes   = 0;

    // reset release, zero-wait memory, plus wrap instance
    do_reset();
    chk("t1_req_dead", 32'(imem_req_o), 32'd0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("t1_req_rise", 32'(imem_req_o), 32'd1);
    chk("t1_addr0", imem_addr_o, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("t1_addr4", imem_addr_o, 32'h4);
    chk("t1_valid", 32'(id_valid_o), 32'd1);
    chk("t1_instr", id_instr_o, 32'h2001_0005);
    chk("t1_op", 32'(id_op_o), 32'h08);
    chk("t1_pc4", id_pc_plus4_o, 32'h4);
    chk("wrap_valid", 32'(wrap_valid), 32'd1);
    chk("wrap_pc4", wrap_pc4, 32'h0);
    chk("wrap_instr", wrap_instr, mem_word(32'hFFFF_FFFC));
    chk("wrap_addr", wrap_addr, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("t1_addr8", imem_addr_o, 32'h8);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // backpressure
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    chk("bp_req", 32'(imem_req_o), 32'd0);
    chk("bp_out", id_instr_o, mem_word(32'h0));
    chk("bp_skid_v", 32'(u_dut.u_skid.valid_o), 32'd1);
    chk("bp_skid", u_dut.u_skid.instr_o, mem_word(32'h4));
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    chk("bp_req2", 32'(imem_req_o), 32'd0);
    chk("bp_issued", 32'(issued.size()), 32'd2);
    takes0 = n_takes;
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    chk("bp_drain", 32'(n_takes - takes0 >= 3), 32'd1);

    // redirect while 0x10 is pending with slow ack
    do_reset();
    slow_addr = 32'h10;
    slow_lat  = 3;
    run_until_addr(32'h10, 20);
    cycle(1'b1, 1'b1, 32'h0000_0042);
    chk("rd_valid_clr", 32'(id_valid_o), 32'd0);
    chk("rd_hold", imem_addr_o, 32'h10);
    idx = issued.size();
    n = 0;
    while (issued.size() == idx && n < 12) begin
      cycle(1'b1, 1'b0, 32'h0);
      n++;
    end
    if (issued.size() > idx) chk("rd_next_addr", issued[idx], 32'h40);
    else chk("timeout_rd", 32'd0, 32'd1);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    slow_addr = 32'hFFFF_FFFF;

    // redirect coinciding with ack at 0x8
    do_reset();
    run_until_addr(32'h8, 20);
    cycle(1'b1, 1'b1, 32'h0000_0100);
    chk("ra_valid_clr", 32'(id_valid_o), 32'd0);
    chk("ra_req", 32'(imem_req_o), 32'd1);
    chk("ra_addr", imem_addr_o, 32'h100);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // redirect during the dead cycle is ignored
    do_reset();
    cycle(1'b1, 1'b1, 32'h0000_0300);
    chk("idle_redir", imem_addr_o, 32'h0);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);

    // async reset while stalled
    do_reset();
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    chk("as_pre_valid", 32'(id_valid_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("as_valid", 32'(id_valid_o), 32'd0);
    chk("as_req", 32'(imem_req_o), 32'd0);
    chk("as_skid", 32'(u_dut.u_skid.valid_o), 32'd0);
    do_reset();
    cycle(1'b1, 1'b0, 32'h0);
    chk("as_restart", imem_addr_o, 32'h0);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // randomized traffic
    do_reset();
    lat_max = 3;
    takes0  = n_takes;
    for (int i = 0; i < 3000; i++) begin
      logic r, d;
      r = ($urandom_range(9) < 7);
      d = (since >= 1) && ($urandom_range(19) == 0);
      cycle(r, d, $urandom & 32'h0000_0FFF);
    end
    chk("rand_progress", 32'(n_takes - takes0 >= 200), 32'd1);

    // async reset with a request outstanding
    n = 0;
    while (!imem_req_o && n < 20) begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("ar_req_pre", 32'(imem_req_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("ar_req", 32'(imem_req_o), 32'd0);
    chk("ar_valid", 32'(id_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the pipelined MIPS core, directly upstream of the main decoder.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Absorbs variable memory latency and backpressure with a 1-entry skid buffer.
- Presents the fetched instruction, its PC+4 and the opcode field (instr[31:26], consumed as the decoder's instr_op_i) through a valid/ready IF/ID output register.
- Handles branch/jump redirects, squashing any in-flight fetch.

Parameters:
ADDR_W, 32, PC / memory address width
DATA_W, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
imem_req_o  out  1  fetch request, held until imem_ack_i
imem_addr_o  out  ADDR_W  fetch address; stable while imem_req_o=1
imem_ack_i  in  1  memory returns imem_rdata_i this cycle; only meaningful when imem_req_o=1
imem_rdata_i  in  DATA_W  fetched instruction
redirect_i  in  1  branch/jump taken: restart fetch at redirect_pc_i
redirect_pc_i  in  ADDR_W  redirect target; bits[1:0] forced to 0
id_ready_i  in  1  decode stage can accept this cycle
id_valid_o  out  1  IF/ID register holds a valid instruction
id_instr_o  out  DATA_W  instruction
id_pc_plus4_o  out  ADDR_W  address of instruction + 4
id_op_o  out  6  id_instr_o[31:26], combinational

Behaviour:
- Reset (rst_i=0, async): pc=RESET_PC, state=S_IDLE, id_valid_o=0, id_instr_o=0, id_pc_plus4_o=0, skid empty, imem_req_o=0.
- imem_req_o=1 only in S_REQ and S_DROP. In S_REQ, imem_addr_o=pc. In S_DROP, imem_addr_o=the squashed address.
- Output transfer ("take") occurs when id_valid_o && id_ready_i.
- FSM transitions:
  - S_IDLE: next clock -> S_REQ (exactly one dead cycle after reset release).
  - S_REQ, ack, output free or taken this cycle: load the output register with {rdata, pc+4}, set valid, pc<=pc+4, stay S_REQ. Back-to-back fetches, 1 instruction/cycle with a zero-wait memory.
  - S_REQ, ack, output full and not taken: write {rdata, pc+4} to skid, pc<=pc+4, -> S_STALL.
  - S_REQ, no ack: hold pc and address.
  - S_STALL: imem_req_o=0. On take: output <= skid, skid cleared, -> S_REQ.
  - S_DROP: hold the request at the old address until ack. Discard the returned data, -> S_REQ at the current pc.
- Redirect (highest priority, any non-IDLE state):
  - Clears id_valid_o and skid; a take in the same cycle is still honoured by the consumer, and the register is cleared afterwards.
  - pc<=redirect_pc_i & ~3.
  - Next state:
    - S_REQ with no ack this cycle -> S_DROP.
    - S_REQ with ack this cycle: data discarded -> S_REQ.
    - S_STALL -> S_REQ.
    - S_DROP: pc updated, stay S_DROP.
  - Redirect in S_IDLE is ignored.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 = 32'h0.
- Output register and skid change only as listed; id_instr_o/id_pc_plus4_o hold their values while id_valid_o=1 and no take occurs.
- Reset mid-transaction abandons the outstanding request. The memory model must tolerate req dropping without ack during reset.
- Never more than one outstanding memory request; never more than 2 instructions buffered (output + skid).

Decomposition:
- Shared package/header: state encodings S_IDLE/S_REQ/S_STALL/S_DROP, OPCODE_MSB=31/OPCODE_LSB=26, PC_INCR=4, RESET_PC default. The decoder shares the opcode field constants.
- One natural sub-module: fetch_skid_buf, a 1-entry {instr, pc_plus4} holding register with load/clear/valid. The remainder is a single FSM + datapath.

Test Plan:
- Reset release with zero-wait memory returning 0x2001_0005 at addr 0, id_ready_i=1:
  - imem_req_o rises 1 cycle after release; addresses 0, 4, 8 on consecutive cycles.
  - id_valid_o=1 with id_instr_o=0x2001_0005, id_op_o=6'b001000, id_pc_plus4_o=4.
- Backpressure with id_ready_i=0 for 5 cycles, zero-wait memory:
  - Output holds instr@0 and skid holds instr@4; req deasserts; no address beyond 8 is issued.
  - On ready=1, instrs @0, @4, @8 emerge in order with no loss or duplication.
- Redirect to 0x0000_0042 while a request to 0x10 is pending with ack delayed 3 cycles:
  - Address 0x10 is held until ack and its data never appears at the output.
  - The next request address is 0x40.
- Redirect coinciding with ack at addr 0x8: data dropped, id_valid_o=0 next cycle, next request address equals the target.
- PC wrap: RESET_PC=32'hFFFF_FFFC, one fetch -> id_pc_plus4_o=0 and next imem_addr_o=0.
- Async reset asserted mid-S_STALL: id_valid_o, imem_req_o and the skid clear immediately (no clock edge); fetch restarts at RESET_PC after release.
